// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 operand issue stage: field widths,
// operand class encoding, the canonical quiet NaN, the buffered pair record
// and the special-case product rules.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  // One buffered operand pair with its precomputed classification.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        special;
    logic [31:0] res;
    logic [2:0]  cls_a;
    logic [2:0]  cls_b;
  } pair_t;

  // Returns {special flag, fixed product}; the product is 0 when no rule fires.
  // Rules are checked in priority order: NaN, Inf*0, Inf, zero.
  function automatic logic [32:0] special_product(input logic [2:0] ca,
                                                  input logic [2:0] cb,
                                                  input logic       s);
    logic [32:0] r;
    r = '0;
    if (ca == CLS_NAN || cb == CLS_NAN)
      r = {1'b1, FP_QNAN};
    else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
      r = {1'b1, FP_QNAN};
    else if (ca == CLS_INF || cb == CLS_INF)
      r = {1'b1, s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      r = {1'b1, s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/m_fp_classify.sv
// Combinational binary32 classifier. Returns the operand class and the word
// that should be forwarded downstream. With FP_ISSUE_SUBNORM_FLUSH_EN defined,
// subnormals are reported as ZERO and replaced by a zero of the same sign.
module m_fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] word,
  output logic [2:0]  cls,
  output logic [31:0] word_out
);

  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;

  assign exp_field  = word[30:23];
  assign frac_field = word[22:0];

  // Decode the exponent/fraction combination into a class and output word.
  always_comb begin
    cls      = CLS_NORM;
    word_out = word;
    if (exp_field == '0) begin
      if (frac_field == '0) begin
        cls = CLS_ZERO;
      end else begin
`ifdef FP_ISSUE_SUBNORM_FLUSH_EN
        cls      = CLS_ZERO;
        word_out = {word[31], 31'b0};
`else
        cls      = CLS_SUB;
`endif
      end
    end else if (exp_field == '1) begin
      cls = (frac_field == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/m_fp_operand_issue.sv
// Operand issue stage for the binary32 multiplier. Collects a serial word
// stream into {A, B} pairs, classifies both operands, precomputes special-case
// products and buffers pairs in a DEPTH-entry FIFO with valid/ready output.
// Optional feature macro: FP_ISSUE_SUBNORM_FLUSH_EN (flush subnormals to zero).
module m_fp_operand_issue
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_a,
  output logic [31:0]                out_b,
  output logic                       out_special,
  output logic [31:0]                out_special_res,
  output logic [2:0]                 out_cls_a,
  output logic [2:0]                 out_cls_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {WAIT_A, WAIT_B} state_t;

  state_t          state;
  logic [31:0]     a_hold;
  pair_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  logic            full;
  logic            accept;
  logic            push;
  logic            pop;
  logic [31:0]     raw_word   [2];
  logic [31:0]     fwd_word   [2];
  logic [2:0]      word_cls   [2];
  logic [32:0]     spec;
  pair_t           new_pair;
  pair_t           head;

  // A is only ever written into the holding register, so it is accepted even
  // when the FIFO is full; only B (which pushes) has to wait for space.
  assign full      = (occ == CW'(DEPTH));
  assign in_ready  = (state == WAIT_A) || !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (state == WAIT_B);
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;

  assign raw_word[0] = a_hold;
  assign raw_word[1] = in_data;

  // Classify the held A and the incoming B at FIFO write time.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
      m_fp_classify u_classify (
        .word     (raw_word[gi]),
        .cls      (word_cls[gi]),
        .word_out (fwd_word[gi])
      );
    end
  endgenerate

  assign spec = special_product(word_cls[0], word_cls[1],
                                fwd_word[0][31] ^ fwd_word[1][31]);

  // Assemble the record that is written on a push.
  always_comb begin
    new_pair         = '0;
    new_pair.a       = fwd_word[0];
    new_pair.b       = fwd_word[1];
    new_pair.special = spec[32];
    new_pair.res     = spec[31:0];
    new_pair.cls_a   = word_cls[0];
    new_pair.cls_b   = word_cls[1];
  end

  // Collector FSM: alternate between holding A and completing the pair with B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_A;
      a_hold <= '0;
    end else if (clr) begin
      state  <= WAIT_A;
    end else if (accept) begin
      if (state == WAIT_A) begin
        a_hold <= in_data;
        state  <= WAIT_B;
      end else begin
        state  <= WAIT_A;
      end
    end
  end

  // Pair FIFO: storage, wrapping pointers and occupancy; clr wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_pair;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Outputs are a mux of FIFO registers on the registered read pointer.
  assign head            = mem[rd_ptr];
  assign out_a           = head.a;
  assign out_b           = head.b;
  assign out_special     = head.special;
  assign out_special_res = head.res;
  assign out_cls_a       = head.cls_a;
  assign out_cls_b       = head.cls_b;
  assign count           = occ;

endmodule
